tk1_mmio_master: RTL and testbench

// Bus initiator for the core register interface (cs/we/address/write_data -> read_data/ready).
// - Takes single-beat read/write commands from an upstream valid/ready stream.
// - Drives one core-bus transaction per command and returns a response stream.
// - Sits between a host-side command source (debug/test bridge, boot sequencer) and any responder core, e.g. tk1.
//

---
 rtl/tk1_mmio_pkg.sv | 17 +
 rtl/tk1_mmio_timer.sv | 32 +++
 rtl/tk1_mmio_master.sv | 135 +++++++++++++
 tb/tb_tk1_mmio_master.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tk1_mmio_pkg.sv
// Shared types and defaults for the tk1 MMIO bus initiator.
// Optional feature macro: TK1_MMIO_TIMEOUT_EN (enables the REQ timeout abort).
package tk1_mmio_pkg;

    localparam int ADDR_WIDTH_DEF     = 8;
    localparam int DATA_WIDTH_DEF     = 32;
    localparam int TIMEOUT_CYCLES_DEF = 64;
    localparam int TXN_CTR_WIDTH      = 16;

    // 2'd3 is not a legal state; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/tk1_mmio_timer.sv
// REQ-phase timeout down-counter. Loaded with CYCLES-1 while cleared, counts
// down on each enabled cycle, and flags expiry once it reaches zero.
// Used only when TK1_MMIO_TIMEOUT_EN is defined.
module tk1_mmio_timer #(
    parameter int CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = $clog2(CYCLES);
    localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // Reload while cleared, otherwise count down towards zero and stick there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= LOAD;
        end else if (clear_i) begin
            cnt_q <= LOAD;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/tk1_mmio_master.sv
// Core-bus initiator: turns single-beat read/write commands into one
// cs/we/address/write_data transaction each and returns a response beat.
// Optional feature macro: TK1_MMIO_TIMEOUT_EN (abort REQ after TIMEOUT_CYCLES).
//
// Handshakes: a beat transfers on a posedge where valid & ready are both high;
// valid never depends on ready, and once raised it is held with stable payload
// until the transfer. cmd_ready is high only in IDLE; rsp_valid only in RESP.
module tk1_mmio_master
    import tk1_mmio_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [ADDR_WIDTH-1:0]    cmd_address,
    input  logic [DATA_WIDTH-1:0]    cmd_write_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_read_data,
    output logic                     rsp_error,
    output logic [TXN_CTR_WIDTH-1:0] txn_count,
    output logic                     cs,
    output logic                     we,
    output logic [ADDR_WIDTH-1:0]    address,
    output logic [DATA_WIDTH-1:0]    write_data,
    input  logic [DATA_WIDTH-1:0]    read_data,
    input  logic                     ready,
    output logic [1:0]               dbg_state
);

    state_e                   state_q;
    logic                     cs_q;
    logic                     we_q;
    logic [ADDR_WIDTH-1:0]    address_q;
    logic [DATA_WIDTH-1:0]    write_data_q;
    logic                     rsp_valid_q;
    logic [DATA_WIDTH-1:0]    rsp_read_data_q;
    logic                     rsp_error_q;
    logic [TXN_CTR_WIDTH-1:0] txn_count_q;
    logic                     timer_expire;

`ifdef TK1_MMIO_TIMEOUT_EN
    // Timer is held loaded outside REQ, so it is fresh on every REQ entry.
    tk1_mmio_timer #(
        .CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_q != REQ),
        .enable_i((state_q == REQ) && !ready),
        .expire_o(timer_expire)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
    assign timer_expire = 1'b0;
`endif

    // Command stall while reset is high so nothing is lost in a reset cycle.
    assign cmd_ready = (state_q == IDLE) && !reset;

    // Single FSM: bus request, response capture and completion counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            cs_q            <= 1'b0;
            we_q            <= 1'b0;
            address_q       <= '0;
            write_data_q    <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_read_data_q <= '0;
            rsp_error_q     <= 1'b0;
            txn_count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        we_q         <= cmd_we;
                        address_q    <= cmd_address;
                        write_data_q <= cmd_write_data;
                        cs_q         <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    // A responder completing in the final cycle beats the timeout.
                    if (ready) begin
                        cs_q            <= 1'b0;
                        we_q            <= 1'b0;
                        rsp_read_data_q <= we_q ? '0 : read_data;
                        rsp_error_q     <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        state_q         <= RESP;
                    end else if (timer_expire) begin
                        cs_q            <= 1'b0;
                        we_q            <= 1'b0;
                        rsp_read_data_q <= '0;
                        rsp_error_q     <= 1'b1;
                        rsp_valid_q     <= 1'b1;
                        state_q         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        txn_count_q <= txn_count_q + 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    cs_q        <= 1'b0;
                    we_q        <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cs            = cs_q;
    assign we            = we_q;
    assign address       = address_q;
    assign write_data    = write_data_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_read_data = rsp_read_data_q;
    assign rsp_error     = rsp_error_q;
    assign txn_count     = txn_count_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_tk1_mmio_master.sv
// Bench for tk1_mmio_master with a tk1-like register stub as responder.
module tb_tk1_mmio_master;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_address;
  logic [DW-1:0] cmd_write_data;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [DW-1:0] rsp_read_data;
  logic [15:0]   txn_count;
  logic          bus_cs, bus_we, bus_ready;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_write_data, bus_read_data;
  logic [1:0]    dbg_state;

  tk1_mmio_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_address(cmd_address), .cmd_write_data(cmd_write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_read_data(rsp_read_data),
    .rsp_error(rsp_error), .txn_count(txn_count),
    .cs(bus_cs), .we(bus_we), .address(bus_address), .write_data(bus_write_data),
    .read_data(bus_read_data), .ready(bus_ready), .dbg_state(dbg_state)
  );

  // ---------------- responder stub ----------------
  logic [DW-1:0] stub_mem [256];
  int   stub_wait;       // cycles of cs before ready rises
  logic stub_never;      // never complete
  int   cs_run;          // cs-high cycles already elapsed in the current pulse
  int   cs_hi_total;     // total cs-high cycles since time 0

  initial begin
    cs_run = 0;
    cs_hi_total = 0;
  end

  assign bus_ready     = bus_cs && !stub_never && (cs_run >= stub_wait);
  assign bus_read_data = stub_mem[bus_address];

  always @(posedge clk) begin
    if (bus_cs) begin
      cs_run      <= cs_run + 1;
      cs_hi_total <= cs_hi_total + 1;
    end else begin
      cs_run <= 0;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) stub_mem[i] = '0;
      stub_mem[0] = 32'h746B3120;
      stub_mem[1] = 32'h6d6b6466;
      stub_mem[2] = 32'h00000005;
    end else if (bus_cs && bus_we && bus_ready) begin
      stub_mem[bus_address] = bus_write_data;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] exp_q [$];
  int model_txn;
  int total = 0;
  int bad = 0;

  task automatic model_init();
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    model_mem[0] = 32'h746B3120;
    model_mem[1] = 32'h6d6b6466;
    model_mem[2] = 32'h00000005;
    model_txn = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One full command/response exchange. Response is held rsp_delay cycles
  // before being consumed, and its stability is checked while held.
  task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int wait_n, input logic never, input int rsp_delay,
                        output logic [DW-1:0] rdata, output logic err,
                        output int lat, output int cs_cycles);
    int n;
    int cs0;
    rdata = '0; err = 1'b0; lat = 0; cs_cycles = 0;
    @(negedge clk);
    stub_wait = wait_n;
    stub_never = never;
    cmd_valid = 1'b1; cmd_we = we; cmd_address = addr; cmd_write_data = wdata;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      check("cmd_ready wait expired", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    cs0 = cs_hi_total;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cs after accept", bus_cs, 1);
    check("bus address", bus_address, addr);
    check("bus we", bus_we, we);
    if (we) check("bus write_data", bus_write_data, wdata);
    while (!rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) begin
      check("rsp_valid wait expired", 0, 1);
      return;
    end
    rdata = rsp_read_data;
    err = rsp_error;
    for (int i = 0; i < rsp_delay; i++) begin
      @(negedge clk);
      check("held rsp_valid", rsp_valid, 1);
      check("held rsp_read_data", rsp_read_data, rdata);
      check("held cmd_ready", cmd_ready, 0);
      check("no cs while held", bus_cs, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    model_txn++;
    cs_cycles = cs_hi_total - cs0;
    check("rsp_valid after handshake", rsp_valid, 0);
    check("txn_count", txn_count, 64'(model_txn & 16'hFFFF));
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [DW-1:0] rd;
    logic          er;
    int            lat, csc, acc;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data, e_data;
    int            r_wait;

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_address = '0; cmd_write_data = '0;
    rsp_ready = 1'b0; stub_wait = 0; stub_never = 1'b0;
    model_init();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("cmd_ready in reset", cmd_ready, 0);
    reset = 1'b0;
    #1;
    check("reset cs", bus_cs, 0);
    check("reset we", bus_we, 0);
    check("reset address", bus_address, 0);
    check("reset write_data", bus_write_data, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_error", rsp_error, 0);
    check("reset rsp_read_data", rsp_read_data, 0);
    check("reset txn_count", txn_count, 0);
    check("reset state", dbg_state, 0);
    check("cmd_ready idle", cmd_ready, 1);

    // Table: reads of fixed registers, write then read-back.
    vecs[0] = '{we: 1'b0, addr: 8'h00, wdata: 32'h0, exp_rdata: 32'h746B3120};
    vecs[1] = '{we: 1'b0, addr: 8'h02, wdata: 32'h0, exp_rdata: 32'h00000005};
    vecs[2] = '{we: 1'b1, addr: 8'h09, wdata: 32'h3, exp_rdata: 32'h00000000};
    vecs[3] = '{we: 1'b0, addr: 8'h09, wdata: 32'h0, exp_rdata: 32'h00000003};
    for (int i = 0; i < 4; i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, 1'b0, 0, rd, er, lat, csc);
      if (vecs[i].we) model_mem[vecs[i].addr] = vecs[i].wdata;
      check($sformatf("vec%0d rsp_read_data", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d rsp_error", i), er, 0);
      check($sformatf("vec%0d cs cycles", i), csc, 1);
      check($sformatf("vec%0d response latency", i), lat, 1);
    end
    check("txn_count after table", txn_count, 4);

    // Response back-pressure: held 10 cycles.
    do_txn(1'b0, 8'h01, 32'h0, 0, 1'b0, 10, rd, er, lat, csc);
    check("held read 0x01 data", rd, 32'h6d6b6466);
    check("held read cs cycles", csc, 1);

    // Peak throughput: command and response streams always open.
    @(negedge clk);
    stub_wait = 0; stub_never = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_address = 8'h02; rsp_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (cmd_ready) acc++;
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    model_txn += 10;
    check("accepts in 30 cycles", acc, 10);
    check("txn_count after burst", txn_count, 64'(model_txn & 16'hFFFF));

`ifdef TK1_MMIO_TIMEOUT_EN
    do_txn(1'b0, 8'h02, 32'h0, 0, 1'b1, 0, rd, er, lat, csc);
    check("timeout cs cycles", csc, TO);
    check("timeout rsp_error", er, 1);
    check("timeout rsp_read_data", rd, 0);
    do_txn(1'b0, 8'h02, 32'h0, TO - 1, 1'b0, 0, rd, er, lat, csc);
    check("last-cycle ready cs cycles", csc, TO);
    check("last-cycle ready rsp_error", er, 0);
    check("last-cycle ready data", rd, model_mem[2]);
`else
    do_txn(1'b0, 8'h02, 32'h0, 40, 1'b0, 0, rd, er, lat, csc);
    check("long wait cs cycles", csc, 41);
    check("long wait rsp_error", er, 0);
    check("long wait data", rd, model_mem[2]);
`endif

    // Reset while the bus request is outstanding.
    @(negedge clk);
    stub_never = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_address = 8'h00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cs before reset", bus_cs, 1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("cs on async reset", bus_cs, 0);
    check("rsp_valid on async reset", rsp_valid, 0);
    check("cmd_ready on async reset", cmd_ready, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    stub_never = 1'b0;
    model_init();
    #1;
    check("txn_count after reset", txn_count, 0);
    do_txn(1'b0, 8'h00, 32'h0, 0, 1'b0, 0, rd, er, lat, csc);
    check("read after reset", rd, 32'h746B3120);
    check("read after reset error", er, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_addr = AW'($urandom_range(0, 15));
      r_data = $urandom;
      r_wait = $urandom_range(0, 4);
      exp_q.push_back(r_we ? '0 : model_mem[r_addr]);
      do_txn(r_we, r_addr, r_data, r_wait, 1'b0, $urandom_range(0, 3), rd, er, lat, csc);
      if (r_we) model_mem[r_addr] = r_data;
      e_data = exp_q.pop_front();
      check("random rsp_read_data", rd, e_data);
      check("random rsp_error", er, 0);
      check("random cs cycles", csc, r_wait + 1);
    end

    // Counter wrap.
    @(negedge clk);
    force dut.txn_count_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.txn_count_q;
    check("txn_count preload", txn_count, 16'hFFFF);
    model_txn = 16'hFFFF;
    do_txn(1'b0, 8'h00, 32'h0, 0, 1'b0, 0, rd, er, lat, csc);
    check("txn_count wrapped", txn_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL global time limit: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $finish;
  end
endmodule
